// File: rtl/sw_debounce.sv
// Per-bit slide-switch debouncer. Captures change events as a one-cycle pulse,
// a sticky software-clearable mask with a level irq, and a wrapping flip counter.
module sw_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic             change_pulse,
    output logic [WIDTH-1:0] change_mask,
    input  logic             clr_valid,
    input  logic [WIDTH-1:0] clr_mask,
    output logic             irq,
    output logic [15:0]      event_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] sw_out_q;
    logic [WIDTH-1:0] sw_out_d;
    logic [WIDTH-1:0] flip;
    logic             change_pulse_q;
    logic             change_pulse_d;
    logic [WIDTH-1:0] change_mask_q;
    logic [WIDTH-1:0] change_mask_d;
    logic [WIDTH-1:0] clr_bits;
    logic [15:0]      event_count_q;
    logic [15:0]      event_count_d;
    logic [15:0]      flip_count;

    // Two-flop synchroniser for the asynchronous switch pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= sw_in;
            s2_q <= s1_q;
        end
    end

    // A bit flips only after DEBOUNCE_CYCLES consecutive edges of disagreement;
    // any agreeing sample restarts the count.
    always_comb begin
        sw_out_d = sw_out_q;
        flip     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == sw_out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                sw_out_d[i] = s2_q[i];
                cnt_d[i]    = '0;
                flip[i]     = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        flip_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            flip_count = flip_count + 16'(flip[i]);
        end
    end

    // Set has priority over clear on the same bit.
    always_comb begin
        clr_bits       = clr_valid ? clr_mask : '0;
        change_mask_d  = (change_mask_q & ~clr_bits) | flip;
        change_pulse_d = |flip;
        event_count_d  = event_count_q + flip_count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_out_q       <= '0;
            change_pulse_q <= 1'b0;
            change_mask_q  <= '0;
            event_count_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sw_out_q       <= sw_out_d;
            change_pulse_q <= change_pulse_d;
            change_mask_q  <= change_mask_d;
            event_count_q  <= event_count_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_out       = sw_out_q;
    assign change_pulse = change_pulse_q;
    assign change_mask  = change_mask_q;
    assign irq          = |change_mask_q;
    assign event_count  = event_count_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: two instances (DEBOUNCE_CYCLES=4 and =1) share inputs and
// are compared every cycle against a window-based reference model, plus directed checks.
module tb_sw_debounce;

    localparam int W = 4;

    typedef struct {
        int           inst;
        logic [127:0] tag;
        logic [25:0]  exp;
        logic [25:0]  care;
    } dchk_t;

    localparam logic [25:0] C_ALL  = 26'h3ff_ffff;
    localparam logic [25:0] C_OUT  = {4'hf, 22'h0};
    localparam logic [25:0] C_MIRQ = {4'h0, 1'b0, 4'hf, 1'b1, 16'h0};
    localparam logic [25:0] C_CNT  = {10'h0, 16'hffff};

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_in;
    logic         clr_valid;
    logic [W-1:0] clr_mask;

    logic [W-1:0] out_a, mask_a, out_b, mask_b;
    logic         pulse_a, irq_a, pulse_b, irq_b;
    logic [15:0]  cnt_a, cnt_b;

    int n_vec = 0;
    int n_err = 0;

    logic [25:0] exp_a[$];
    logic [25:0] exp_b[$];
    dchk_t       dir_q[$];

    always #5 clk = ~clk;

    sw_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut_a (
        .clk(clk), .reset(reset), .sw_in(sw_in), .sw_out(out_a),
        .change_pulse(pulse_a), .change_mask(mask_a), .clr_valid(clr_valid),
        .clr_mask(clr_mask), .irq(irq_a), .event_count(cnt_a)
    );

    sw_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(1), .CNT_W(1)) dut_b (
        .clk(clk), .reset(reset), .sw_in(sw_in), .sw_out(out_b),
        .change_pulse(pulse_b), .change_mask(mask_b), .clr_valid(clr_valid),
        .clr_mask(clr_mask), .irq(irq_b), .event_count(cnt_b)
    );

    function automatic logic [25:0] pk(input logic [3:0] o, input logic p,
                                       input logic [3:0] m, input logic i,
                                       input logic [15:0] c);
        return {o, p, m, i, c};
    endfunction

    function automatic int dcyc(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Reference model: a bit's output flips when the last D synchronised samples
    // all disagree with it. Samples reach the debouncer two edges after capture.
    logic [3:0]  hist [2][4];
    int          hv [2];
    logic [3:0]  m_out [2];
    logic [3:0]  m_mask [2];
    logic        m_pulse [2];
    logic [15:0] m_cnt [2];
    logic [3:0]  dly1, dly2;

    always @(posedge clk) begin
        logic [3:0] flips;
        bit         all_diff;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                hv[k] = 0; m_out[k] = '0; m_mask[k] = '0; m_pulse[k] = 1'b0; m_cnt[k] = '0;
            end
            dly1 = '0;
            dly2 = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = dly2;
                if (hv[k] < 4) hv[k]++;
                flips = '0;
                for (int b = 0; b < W; b++) begin
                    all_diff = (hv[k] >= dcyc(k));
                    for (int j = 0; j < dcyc(k); j++)
                        if (hist[k][j][b] == m_out[k][b]) all_diff = 1'b0;
                    if (all_diff) flips[b] = 1'b1;
                end
                m_out[k]   = m_out[k] ^ flips;
                m_pulse[k] = (flips != 0);
                m_mask[k]  = (m_mask[k] & ~(clr_valid ? clr_mask : 4'h0)) | flips;
                m_cnt[k]   = m_cnt[k] + 16'($countones(flips));
            end
            dly2 = dly1;
            dly1 = sw_in;
        end
        exp_a.push_back(pk(m_out[0], m_pulse[0], m_mask[0], m_mask[0] != 0, m_cnt[0]));
        exp_b.push_back(pk(m_out[1], m_pulse[1], m_mask[1], m_mask[1] != 0, m_cnt[1]));
    end

    // Monitor: every cycle pops the model's expectation and any directed checks.
    always @(negedge clk) begin
        logic [25:0] act_a, act_b, act, e;
        dchk_t       d;
        act_a = pk(out_a, pulse_a, mask_a, irq_a, cnt_a);
        act_b = pk(out_b, pulse_b, mask_b, irq_b, cnt_b);
        if (exp_a.size() != 0) begin
            e = exp_a.pop_front();
            n_vec++;
            if (act_a !== e) begin
                n_err++;
                $display("FAIL model_d4 t=%0t got out=%b pulse=%b mask=%b irq=%b cnt=%h exp out=%b pulse=%b mask=%b irq=%b cnt=%h",
                         $time, act_a[25:22], act_a[21], act_a[20:17], act_a[16], act_a[15:0],
                         e[25:22], e[21], e[20:17], e[16], e[15:0]);
            end
        end
        if (exp_b.size() != 0) begin
            e = exp_b.pop_front();
            n_vec++;
            if (act_b !== e) begin
                n_err++;
                $display("FAIL model_d1 t=%0t got out=%b pulse=%b mask=%b irq=%b cnt=%h exp out=%b pulse=%b mask=%b irq=%b cnt=%h",
                         $time, act_b[25:22], act_b[21], act_b[20:17], act_b[16], act_b[15:0],
                         e[25:22], e[21], e[20:17], e[16], e[15:0]);
            end
        end
        while (dir_q.size() != 0) begin
            d   = dir_q.pop_front();
            act = (d.inst == 0) ? act_a : act_b;
            n_vec++;
            if ((act & d.care) !== (d.exp & d.care)) begin
                n_err++;
                $display("FAIL %0s inst=%0d t=%0t got out=%b pulse=%b mask=%b irq=%b cnt=%h exp out=%b pulse=%b mask=%b irq=%b cnt=%h care=%h",
                         d.tag, d.inst, $time, act[25:22], act[21], act[20:17], act[16], act[15:0],
                         d.exp[25:22], d.exp[21], d.exp[20:17], d.exp[16], d.exp[15:0], d.care);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dchk(input int inst, input logic [127:0] tag,
                        input logic [25:0] exp, input logic [25:0] care);
        dchk_t d;
        d.inst = inst; d.tag = tag; d.exp = exp; d.care = care;
        dir_q.push_back(d);
    endtask

    task automatic clear(input logic [3:0] m);
        clr_valid = 1'b1;
        clr_mask  = m;
        tick(1);
        clr_valid = 1'b0;
        clr_mask  = '0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
        int r;
        reset = 1'b1; sw_in = '0; clr_valid = 1'b0; clr_mask = '0;
        tick(2);
        dchk(0, "reset_state", pk(4'h0, 1'b0, 4'h0, 1'b0, 16'h0), C_ALL);
        reset = 1'b0;
        tick(2);

        // Clean step: 3-edge latency at D=1, 6 edges at D=4.
        sw_in = 4'b0001;
        tick(2);
        dchk(1, "d1_pre", pk(4'h0, 0, 0, 0, 0), C_OUT);
        tick(1);
        dchk(1, "d1_flip", pk(4'b0001, 1'b1, 4'b0001, 1'b1, 16'd1), C_ALL);
        tick(2);
        dchk(0, "step_pre", pk(4'h0, 0, 0, 0, 0), C_OUT);
        tick(1);
        dchk(0, "step_flip", pk(4'b0001, 1'b1, 4'b0001, 1'b1, 16'd1), C_ALL);
        tick(1);
        dchk(0, "step_pulse_end", pk(4'b0001, 1'b0, 4'b0001, 1'b1, 16'd1), C_ALL);

        // Bounce on bit 2: only the final run of four highs counts.
        for (int i = 0; i < 9; i++) begin
            sw_in[2] = bp[i][0];
            tick(1);
        end
        tick(1);
        dchk(0, "bounce_pre", pk(4'b0001, 0, 0, 0, 0), C_OUT);
        tick(1);
        dchk(0, "bounce_flip", pk(4'b0101, 1'b1, 4'b0101, 1'b1, 16'd2), C_ALL);
        tick(2);

        // Two bits stepping together.
        clear(4'hf);
        dchk(0, "clear_all", pk(0, 0, 4'h0, 1'b0, 0), C_MIRQ);
        sw_in = 4'b1100;
        tick(5);
        dchk(0, "dual_pre", pk(4'b0101, 0, 0, 0, 0), C_OUT);
        tick(1);
        dchk(0, "dual_flip", pk(4'b1100, 1'b1, 4'b1001, 1'b1, 16'd4), C_ALL);
        tick(2);

        // Clear racing a set on bit 1.
        sw_in = 4'b1110;
        tick(5);
        clr_valid = 1'b1;
        clr_mask  = 4'hf;
        tick(1);
        clr_valid = 1'b0;
        clr_mask  = '0;
        dchk(0, "clr_race", pk(4'b1110, 1'b1, 4'b0010, 1'b1, 16'd5), C_ALL);
        clear(4'b0010);
        dchk(0, "clr_second", pk(0, 0, 4'h0, 1'b0, 0), C_MIRQ);
        tick(2);

        // Reset while bit 0 is mid-count.
        sw_in = 4'b1111;
        tick(4);
        reset = 1'b1;
        tick(1);
        dchk(0, "mid_reset", pk(0, 0, 0, 0, 0), C_ALL);
        dchk(1, "mid_reset", pk(0, 0, 0, 0, 0), C_ALL);
        reset = 1'b0;
        tick(5);
        dchk(0, "post_reset_pre", pk(4'h0, 0, 0, 0, 0), C_ALL);
        tick(1);
        dchk(0, "post_reset_flip", pk(4'hf, 1'b1, 4'hf, 1'b1, 16'd4), C_ALL);
        tick(2);

        // Randomised inputs, glitches and clears.
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 9);
            if (r < 2) sw_in = 4'($urandom_range(0, 15));
            else if (r == 2) sw_in[$urandom_range(0, 3)] = ~sw_in[$urandom_range(0, 3)];
            clr_valid = ($urandom_range(0, 7) == 0);
            clr_mask  = 4'($urandom_range(0, 15));
            tick(1);
        end
        clr_valid = 1'b0;
        clr_mask  = '0;

        // Counter wrap on the D=1 instance: every bit flips every edge.
        reset = 1'b1;
        sw_in = '0;
        tick(1);
        reset = 1'b0;
        for (int k = 0; k < 16384; k++) begin
            sw_in = k[0] ? 4'h0 : 4'hf;
            tick(1);
        end
        tick(1);
        dchk(1, "wrap_pre", pk(0, 0, 0, 0, 16'hfffc), C_CNT);
        tick(1);
        dchk(1, "wrap_zero", pk(4'h0, 1'b1, 4'hf, 1'b1, 16'h0000), C_ALL);
        dchk(0, "wrap_d4_idle", pk(0, 0, 0, 0, 0), C_ALL);
        tick(2);
        dchk(1, "wrap_settled", pk(4'h0, 1'b0, 4'hf, 1'b1, 16'h0000), C_ALL);

        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
